instr_fetch_unit: RTL

//  Fetch stage downstream of the PC-adjust stage. Owns the architectural fetch PC and issues

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests instruction memory over
// req/ack, buffers returned instructions in a small FIFO and hands them to
// decode over valid/ready. A redirect reloads the PC and flushes the FIFO.
module instr_fetch_unit #(
  parameter int            AW       = 16,
  parameter int            IW       = 16,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] fetch_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [AW-1:0] STEP = AW'(PC_STEP);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] drop_addr_q, drop_addr_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [IW-1:0] instr_q [DEPTH];
  logic [AW-1:0] ipc_q   [DEPTH];
  logic          push, pop;

  // Next-state and request generation; DROP keeps the request up until the
  // memory finishes the transfer that a redirect made stale.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = (count_q < FULL);
        if (redirect && imem_req && !imem_ack) state_d = S_DROP;
      end
      S_DROP: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // While draining a stale request the address stays at what the memory saw,
  // even though fetch_pc already shows the redirect target.
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign fetch_pc  = pc_q;

  // Redirect suppresses any same-cycle push or pop.
  assign push     = (state_q == S_FETCH) && imem_req && imem_ack && !redirect;
  assign pop      = if_valid && if_ready && !redirect;
  assign if_valid = (count_q != '0);
  assign if_instr = instr_q[rd_ptr_q];
  assign if_pc    = ipc_q[rd_ptr_q];

  // PC, occupancy and stale-address next-state; redirect takes priority.
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    drop_addr_d = drop_addr_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      count_d = '0;
    end else begin
      if (push) pc_d = pc_q + STEP;
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    if ((state_q == S_FETCH) && (state_d == S_DROP)) drop_addr_d = pc_q;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
    end
  end

  // FIFO pointers; a flush realigns both to entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FIFO storage, cleared on reset so if_instr/if_pc read zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      ipc_q[wr_ptr_q]   <= pc_q;
    end
  end

endmodule
